softex_tcdm_arbiter: RTL and testbench
======================================

# softex_tcdm_arbiter

Shares the single wide HCI TCDM master port of the softex accelerator between the load streamer (read-only) and the store streamer (write-only). Round-robin arbitration with a bounded burst quantum, in-order response routing via a tag FIFO, and a cap on outstanding transactions. Sits between the streamers and the wrapper's `tcdm` port; the controller sees it only through `clear_i` and `idle_o`.

## Interface
- `DW`, default `DATA_W` (128): TCDM data width. `DW/8` byte enables.
- `AW`, default 32: address width.
- `MAX_OUTSTANDING`, default 4: tag FIFO depth. Maximum granted-but-unanswered transactions.
- `BURST_LEN`, default 8: maximum consecutive grants to one owner while the other requester waits.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear. Same effect as reset. Asserted only while `idle_o`=1.
- `ld_req_i` in 1, `ld_gnt_o` out 1, `ld_add_i` in AW: load request channel.
- `ld_r_data_o` out DW, `ld_r_valid_o` out 1, `ld_r_ready_i` in 1: load response channel.
- `st_req_i` in 1, `st_gnt_o` out 1, `st_add_i` in AW, `st_data_i` in DW, `st_be_i` in DW/8: store request channel.
- `tcdm_req_o` out 1, `tcdm_gnt_i` in 1, `tcdm_add_o` out AW, `tcdm_wen_o` out 1 (1=read), `tcdm_be_o` out DW/8, `tcdm_data_o` out DW: master request.
- `tcdm_r_data_i` in DW, `tcdm_r_valid_i` in 1, `tcdm_r_ready_o` out 1: master response. Responses arrive in order, one per granted transaction, reads and writes alike.
- `idle_o` out 1: FIFO empty and no requester active.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current tag FIFO count.

## Operation
- FSM states: IDLE, LOAD, STORE. Registered `last_owner` starts as STORE after reset/clear, so load wins the first tie.
- Selection, combinational each cycle:
  - IDLE: the single requester wins. On a tie, the requester opposite `last_owner` wins.
  - LOAD: load stays selected while `ld_req_i`=1, unless `burst_cnt`==BURST_LEN and `st_req_i`=1. In that case store is selected. STORE is symmetric.
  - No requester: next state IDLE.
- Issue:
  - `tcdm_req_o` = selected req AND NOT fifo_full.
  - Address, data, be and wen are muxed from the selected channel. Store sets `wen`=0 and `be`=`st_be_i`. Load sets `wen`=1 and `be`=all ones. Data is 0 when load is selected.
  - `ld_gnt_o`/`st_gnt_o` = `tcdm_gnt_i` AND `tcdm_req_o` AND that channel selected.
- Handshake (req/gnt):
  - A requester holds req and its payload stable until gnt.
  - Accept = `tcdm_req_o`&`tcdm_gnt_i`.
  - On accept: push tag (1=read) to FIFO, set state/`last_owner` to the accepted channel.
  - `burst_cnt` increments on accept for the same owner. It reloads to 1 on an owner switch and clears in IDLE. `burst_cnt` saturates at BURST_LEN.
- Responses:
  - Head tag read: `ld_r_valid_o`=`tcdm_r_valid_i`, `ld_r_data_o`=`tcdm_r_data_i`, `tcdm_r_ready_o`=`ld_r_ready_i`.
  - Head tag write: `ld_r_valid_o`=0, `tcdm_r_ready_o`=1. The write ack is drained internally.
  - FIFO empty: `tcdm_r_ready_o`=1. A `tcdm_r_valid_i` with an empty FIFO is a protocol error (assertion).
  - Pop on `tcdm_r_valid_i`&`tcdm_r_ready_o`.
- Boundaries:
  - FIFO full: no request is issued and the FSM state holds.
  - Full plus pop in the same cycle: still no issue, because full is evaluated on the registered count.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
  - Reset mid-operation: FIFO empty, in-flight responses are lost. The system guarantees reset only when the TCDM is quiescent.
- `idle_o` = fifo_empty AND NOT `ld_req_i` AND NOT `st_req_i`.

## Timing
- Request path is combinational: grant and accept happen in the same cycle as the request. No added latency.
- Response path is combinational from `tcdm_r_*` to `ld_r_*`. Zero cycles.
- Registered state: FSM, `last_owner`, `burst_cnt`, FIFO.
- Reset values: state=IDLE, `burst_cnt`=0, `last_owner`=STORE, FIFO empty.
- Resulting outputs with inputs low: `tcdm_req_o`=0, `ld_gnt_o`=`st_gnt_o`=0, `ld_r_valid_o`=0, `tcdm_r_ready_o`=1, `idle_o`=1, `outstanding_o`=0.
- Outputs are driven combinationally from internal state, never as undefined values.
- Worst-case wait for a persistently requesting channel: BURST_LEN grants to the other channel.

## Structure
- `softex_pkg` gains typedef `softex_arb_state_e` {ARB_IDLE, ARB_LOAD, ARB_STORE} and typedef `softex_tcdm_tag_t` (1 bit, read/write).
- Sub-module `softex_tag_fifo`: 1-bit-wide FIFO of depth MAX_OUTSTANDING with push, pop, full, empty and count, plus async reset and clear.
- Arbiter FSM and muxing live in the top module.

## Test plan
- Load-only stream, 6 requests, `tcdm_gnt_i`=1, responses one cycle later: 6 `ld_gnt_o` pulses, 6 `ld_r_valid_o` with matching data, `st_gnt_o` never 1, `idle_o`=1 at the end.
- Both request from reset, BURST_LEN=8: grants go to load first, 8 loads, then 8 stores, then loads again. `wen` toggles accordingly.
- Hold `tcdm_r_valid_i`=0 with 5 requests pending: exactly 4 accepts, `outstanding_o`=4, `tcdm_req_o`=0. One response pops the FIFO and the next cycle issues.
- Interleave L,S,L with responses in order: the write ack is not visible on `ld_r_valid_o`. Both load data arrive in order. `tcdm_r_ready_o`=1 during the write ack.
- `ld_r_ready_i`=0 with a read at the head: `tcdm_r_ready_o`=0 and the FIFO does not pop. Asserting ready pops exactly one entry.
- Reset asserted asynchronously mid-burst with 3 outstanding: all outputs return to reset values immediately. `outstanding_o`=0 and `idle_o`=1 once requesters drop.

Source files
------------

// File: rtl/softex_pkg.sv
// Shared softex types: TCDM arbiter FSM states and the response tag that
// records whether an in-flight transaction was a read or a write.
package softex_pkg;

    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_STORE = 2'd2
    } softex_arb_state_e;

    typedef enum logic {
        TAG_WRITE = 1'b0,
        TAG_READ  = 1'b1
    } softex_tcdm_tag_t;

endpackage

// File: rtl/softex_tcdm_arbiter_if.sv
// HCI-style TCDM channel: req/gnt request phase plus r_valid/r_ready response.
interface softex_tcdm_arbiter_if #(
    parameter int unsigned DW = softex_pkg::DATA_W,
    parameter int unsigned AW = 32
);
    import softex_pkg::*;

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [DW-1:0]   r_data;
    logic            r_valid;
    logic            r_ready;

    modport master (output req, add, wen, be, data, r_ready,
                    input  gnt, r_data, r_valid);
    modport slave  (input  req, add, wen, be, data, r_ready,
                    output gnt, r_data, r_valid);

endinterface

// File: rtl/softex_tag_fifo.sv
// 1-bit tag FIFO remembering read/write order of granted TCDM transactions.
module softex_tag_fifo
    import softex_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  softex_tcdm_tag_t tag_i,
    input  logic             pop_i,
    output softex_tcdm_tag_t tag_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    softex_tcdm_tag_t mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign tag_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_next(rd_ptr_q);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides whether the head is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= tag_i;
    end

endmodule

// File: rtl/softex_tcdm_arbiter.sv
// Round-robin arbiter sharing the softex TCDM master port between the load
// and store streamers, with burst quantum and in-order response routing.
module softex_tcdm_arbiter
    import softex_pkg::*;
#(
    parameter  int unsigned DW              = DATA_W,
    parameter  int unsigned AW              = 32,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    parameter  int unsigned BURST_LEN       = 8,
    localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    softex_tcdm_arbiter_if.slave  ld,
    softex_tcdm_arbiter_if.slave  st,
    softex_tcdm_arbiter_if.master tcdm,
    output logic                  idle_o,
    output logic [OW-1:0]         outstanding_o
);

    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    softex_arb_state_e state_q, state_d, last_owner_q, last_owner_d, sel;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              burst_at_max, issue, accept, fifo_full, fifo_empty, head_read;
    softex_tcdm_tag_t  head_tag;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= ARB_STORE;
            burst_cnt_q  <= '0;
        end else if (clear_i) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= ARB_STORE;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        sel          = ARB_IDLE;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        burst_at_max = (burst_cnt_q == BW'(BURST_LEN));

        unique case (state_q)
            ARB_LOAD: begin
                if (ld.req && !(burst_at_max && st.req)) sel = ARB_LOAD;
                else if (st.req)                         sel = ARB_STORE;
            end
            ARB_STORE: begin
                if (st.req && !(burst_at_max && ld.req)) sel = ARB_STORE;
                else if (ld.req)                         sel = ARB_LOAD;
            end
            default: begin
                if (ld.req && st.req)
                    sel = (last_owner_q == ARB_STORE) ? ARB_LOAD : ARB_STORE;
                else if (ld.req) sel = ARB_LOAD;
                else if (st.req) sel = ARB_STORE;
            end
        endcase

        // Full is judged on the registered count, so a same-cycle pop cannot unblock issue.
        issue  = (sel != ARB_IDLE) && !fifo_full;
        accept = issue && tcdm.gnt;

        if (accept) begin
            state_d      = sel;
            last_owner_d = sel;
            if (sel == state_q) burst_cnt_d = burst_at_max ? burst_cnt_q : burst_cnt_q + BW'(1);
            else                burst_cnt_d = BW'(1);
        end else if (!fifo_full && sel == ARB_IDLE) begin
            state_d = ARB_IDLE;
        end
        if (state_d == ARB_IDLE) burst_cnt_d = '0;
    end

    always_comb begin
        tcdm.req  = issue;
        tcdm.add  = (sel == ARB_STORE) ? st.add  : ld.add;
        tcdm.wen  = (sel != ARB_STORE);
        tcdm.be   = (sel == ARB_STORE) ? st.be   : '1;
        tcdm.data = (sel == ARB_STORE) ? st.data : '0;
        ld.gnt    = tcdm.gnt && issue && (sel == ARB_LOAD);
        st.gnt    = tcdm.gnt && issue && (sel == ARB_STORE);

        // Write acks are swallowed here; only read responses reach the load streamer.
        head_read    = !fifo_empty && (head_tag == TAG_READ);
        ld.r_valid   = head_read && tcdm.r_valid;
        ld.r_data    = tcdm.r_data;
        tcdm.r_ready = head_read ? ld.r_ready : 1'b1;
        st.r_valid   = 1'b0;
        st.r_data    = '0;
    end

    softex_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (accept),
        .tag_i   ((sel == ARB_LOAD) ? TAG_READ : TAG_WRITE),
        .pop_i   (tcdm.r_valid && tcdm.r_ready),
        .tag_o   (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign idle_o = fifo_empty && !ld.req && !st.req;

    resp_without_tag_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tcdm.r_valid && fifo_empty));

endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// Directed bench for softex_tcdm_arbiter: a per-cycle vector table plus
// hand-written burst, full-FIFO, clear and async-reset sequences.
module tb_softex_tcdm_arbiter;
    import softex_pkg::*;

    localparam int DW = 128;
    localparam int AW = 32;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       clear_i = 1'b0;
    logic       idle_o;
    logic [2:0] outstanding_o;

    softex_tcdm_arbiter_if #(.DW(DW), .AW(AW)) ld_if ();
    softex_tcdm_arbiter_if #(.DW(DW), .AW(AW)) st_if ();
    softex_tcdm_arbiter_if #(.DW(DW), .AW(AW)) tcdm_if ();

    softex_tcdm_arbiter #(.DW(DW), .AW(AW), .MAX_OUTSTANDING(4), .BURST_LEN(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .ld            (ld_if.slave),
        .st            (st_if.slave),
        .tcdm          (tcdm_if.master),
        .idle_o        (idle_o),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ld_if.req = 1'b0; ld_if.add = '0; ld_if.wen = 1'b1; ld_if.be = '0; ld_if.data = '0;
        ld_if.r_ready = 1'b1;
        st_if.req = 1'b0; st_if.add = '0; st_if.wen = 1'b0; st_if.be = '0; st_if.data = '0;
        st_if.r_ready = 1'b1;
        tcdm_if.gnt = 1'b0; tcdm_if.r_valid = 1'b0; tcdm_if.r_data = '0;
    endtask

    typedef struct {
        logic       ld_req, st_req, gnt, r_valid, ld_r_ready;
        logic [7:0] r_tag;
        logic       e_req, e_ld_gnt, e_st_gnt, e_wen, e_ld_rv, e_r_ready, e_idle;
        int         e_out;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int ld_gnts, ld_rvs, accepts;
        logic prev_load, exp_load;

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset state with all inputs low.
        #1;
        check("rst_tcdm_req", tcdm_if.req, 1'b0);
        check("rst_ld_gnt", ld_if.gnt, 1'b0);
        check("rst_st_gnt", st_if.gnt, 1'b0);
        check("rst_ld_rv", ld_if.r_valid, 1'b0);
        check("rst_r_ready", tcdm_if.r_ready, 1'b1);
        check("rst_idle", idle_o, 1'b1);
        check("rst_out", outstanding_o, 3'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Load-only stream: 6 requests, each answered one cycle later.
        ld_gnts = 0; ld_rvs = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            ld_if.req       = (i < 6);
            ld_if.add       = 32'h1000 + 32'(4 * i);
            tcdm_if.gnt     = 1'b1;
            tcdm_if.r_valid = (i >= 1);
            tcdm_if.r_data  = 128'hD0 + 128'(i - 1);
            #1;
            if (ld_if.gnt) ld_gnts++;
            if (ld_if.r_valid) ld_rvs++;
            check("ldonly_ld_gnt", ld_if.gnt, (i < 6));
            check("ldonly_st_gnt", st_if.gnt, 1'b0);
            check("ldonly_ld_rv", ld_if.r_valid, (i >= 1));
            if (i >= 1) check("ldonly_rdata", ld_if.r_data, 128'hD0 + 128'(i - 1));
            if (i < 6) begin
                check("ldonly_add", tcdm_if.add, 32'h1000 + 32'(4 * i));
                check("ldonly_wen", tcdm_if.wen, 1'b1);
            end
        end
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("ldonly_gnt_count", ld_gnts, 6);
        check("ldonly_rv_count", ld_rvs, 6);
        check("ldonly_idle", idle_o, 1'b1);

        // Per-cycle table: L,S,L interleave then read-ready back-pressure.
        //          ld st gnt rv rdy tag    req ldg stg wen ldrv rr idle out
        vecs[0]  = '{1, 0, 1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 1, 8'hA1,  1, 0, 1, 0, 1, 1, 0, 1};
        vecs[2]  = '{1, 0, 1, 1, 1, 8'hB2,  1, 1, 0, 1, 0, 1, 0, 1};
        vecs[3]  = '{0, 0, 0, 1, 1, 8'hA3,  0, 0, 0, 1, 1, 1, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 1, 8'h00,  0, 0, 0, 1, 0, 1, 1, 0};
        vecs[5]  = '{1, 0, 1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 1, 1, 0, 8'hC6,  1, 1, 0, 1, 1, 0, 0, 1};
        vecs[7]  = '{0, 0, 0, 1, 0, 8'hC6,  0, 0, 0, 1, 1, 0, 0, 2};
        vecs[8]  = '{0, 0, 0, 1, 1, 8'hC6,  0, 0, 0, 1, 1, 1, 0, 2};
        vecs[9]  = '{0, 0, 0, 1, 1, 8'hD9,  0, 0, 0, 1, 1, 1, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 1, 8'h00,  0, 0, 0, 1, 0, 1, 1, 0};
        for (int r = 0; r < 11; r++) begin
            @(negedge clk_i);
            ld_if.req       = vecs[r].ld_req;
            ld_if.add       = 32'(r);
            ld_if.r_ready   = vecs[r].ld_r_ready;
            st_if.req       = vecs[r].st_req;
            st_if.add       = 32'(100 + r);
            tcdm_if.gnt     = vecs[r].gnt;
            tcdm_if.r_valid = vecs[r].r_valid;
            tcdm_if.r_data  = 128'(vecs[r].r_tag);
            #1;
            check($sformatf("vec%0d_req", r), tcdm_if.req, vecs[r].e_req);
            check($sformatf("vec%0d_ld_gnt", r), ld_if.gnt, vecs[r].e_ld_gnt);
            check($sformatf("vec%0d_st_gnt", r), st_if.gnt, vecs[r].e_st_gnt);
            if (vecs[r].e_req) check($sformatf("vec%0d_wen", r), tcdm_if.wen, vecs[r].e_wen);
            check($sformatf("vec%0d_ld_rv", r), ld_if.r_valid, vecs[r].e_ld_rv);
            if (vecs[r].e_ld_rv) check($sformatf("vec%0d_rdata", r), ld_if.r_data, 128'(vecs[r].r_tag));
            check($sformatf("vec%0d_r_ready", r), tcdm_if.r_ready, vecs[r].e_r_ready);
            check($sformatf("vec%0d_idle", r), idle_o, vecs[r].e_idle);
            check($sformatf("vec%0d_out", r), outstanding_o, 3'(vecs[r].e_out));
        end

        // Both requesters from reset: 8 loads, 8 stores, then loads again.
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        prev_load = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_i);
            exp_load        = (i < 8) || (i >= 16);
            ld_if.req       = 1'b1;
            ld_if.add       = 32'(i);
            st_if.req       = 1'b1;
            st_if.add       = 32'(200 + i);
            st_if.data      = 128'h5000 + 128'(i);
            st_if.be        = 16'h0FF0;
            tcdm_if.gnt     = 1'b1;
            tcdm_if.r_valid = (i >= 1);
            tcdm_if.r_data  = 128'(i);
            #1;
            check($sformatf("burst%0d_ld_gnt", i), ld_if.gnt, exp_load);
            check($sformatf("burst%0d_st_gnt", i), st_if.gnt, !exp_load);
            check($sformatf("burst%0d_wen", i), tcdm_if.wen, exp_load);
            check($sformatf("burst%0d_be", i), tcdm_if.be, exp_load ? 16'hFFFF : 16'h0FF0);
            check($sformatf("burst%0d_data", i), tcdm_if.data, exp_load ? 128'h0 : 128'h5000 + 128'(i));
            check($sformatf("burst%0d_ld_rv", i), ld_if.r_valid, (i >= 1) && prev_load);
            prev_load = exp_load;
        end
        @(negedge clk_i);
        ld_if.req = 1'b0; st_if.req = 1'b0; tcdm_if.gnt = 1'b0;
        tcdm_if.r_valid = 1'b1; tcdm_if.r_data = 128'd24;
        #1;
        check("burst_last_ld_rv", ld_if.r_valid, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("burst_idle", idle_o, 1'b1);

        // No responses: FIFO caps at 4, full+pop still blocks, next cycle issues.
        accepts = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            ld_if.req = 1'b1; ld_if.add = 32'h40 + 32'(c); tcdm_if.gnt = 1'b1;
            #1;
            if (ld_if.gnt) accepts++;
            if (c >= 4) check($sformatf("full%0d_req", c), tcdm_if.req, 1'b0);
        end
        check("full_accepts", accepts, 4);
        check("full_out", outstanding_o, 3'd4);
        @(negedge clk_i);
        tcdm_if.r_valid = 1'b1; tcdm_if.r_data = 128'h77;
        #1;
        check("fullpop_req", tcdm_if.req, 1'b0);
        check("fullpop_ld_rv", ld_if.r_valid, 1'b1);
        @(negedge clk_i);
        tcdm_if.r_valid = 1'b0;
        #1;
        check("afterpop_req", tcdm_if.req, 1'b1);
        check("afterpop_ld_gnt", ld_if.gnt, 1'b1);
        check("afterpop_out", outstanding_o, 3'd3);
        @(negedge clk_i);
        ld_if.req = 1'b0; tcdm_if.gnt = 1'b0; tcdm_if.r_valid = 1'b1;
        #1;
        check("refill_out", outstanding_o, 3'd4);
        repeat (4) @(negedge clk_i);
        tcdm_if.r_valid = 1'b0;
        #1;
        check("drain_out", outstanding_o, 3'd0);
        check("drain_idle", idle_o, 1'b1);

        // Tie after a load owner goes to store; clear restores load priority.
        @(negedge clk_i);
        ld_if.req = 1'b1; st_if.req = 1'b1;
        #1;
        check("tie_req", tcdm_if.req, 1'b1);
        check("tie_store_wins", tcdm_if.wen, 1'b0);
        @(negedge clk_i);
        ld_if.req = 1'b0; st_if.req = 1'b0; clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0; ld_if.req = 1'b1; st_if.req = 1'b1;
        #1;
        check("clear_load_wins", tcdm_if.wen, 1'b1);

        // Async reset with 3 reads outstanding.
        @(negedge clk_i);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            ld_if.req = 1'b1; tcdm_if.gnt = 1'b1;
        end
        @(negedge clk_i);
        #1;
        check("prerst_out", outstanding_o, 3'd3);
        #1;
        rst_ni = 1'b0;
        #1;
        check("asyncrst_out", outstanding_o, 3'd0);
        check("asyncrst_r_ready", tcdm_if.r_ready, 1'b1);
        check("asyncrst_ld_rv", ld_if.r_valid, 1'b0);
        ld_if.req = 1'b0; tcdm_if.gnt = 1'b0;
        #1;
        check("asyncrst_req", tcdm_if.req, 1'b0);
        check("asyncrst_ld_gnt", ld_if.gnt, 1'b0);
        check("asyncrst_st_gnt", st_if.gnt, 1'b0);
        check("asyncrst_idle", idle_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("postrst_idle", idle_o, 1'b1);
        check("postrst_out", outstanding_o, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
